// File: rtl/regfile_arbiter_2x.sv
// regfile_arbiter_2x: round-robin sharing of one 1W/1R register file between two requesters
module regfile_arbiter_2x #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_wr_e,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state_q, state_d;
    logic prio_q, prio_d, own_q, own_d, we_q, we_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, wr_e_q, wr_e_d, busy_q, busy_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            wr_e_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            own_q     <= own_d;
            we_q      <= we_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            wr_e_q    <= wr_e_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
        end
    end
    // Port outputs for ACCESS are loaded at the grant edge so they are registered during ACCESS.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        own_d     = own_q;
        we_d      = we_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        wr_e_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                own_d     = req1 && (!req0 || prio_q);
                we_d      = own_d ? we1 : we0;
                wr_e_d    = we_d;
                wr_addr_d = we_d ? (own_d ? addr1 : addr0) : wr_addr_q;
                wr_data_d = we_d ? (own_d ? wdata1 : wdata0) : wr_data_q;
                rd_addr_d = we_d ? rd_addr_q : (own_d ? addr1 : addr0);
                state_d   = ACCESS;
            end
            ACCESS: begin
                ack0_d   = !own_q;
                ack1_d   = own_q;
                rdata0_d = (!own_q && !we_q) ? rf_rd_data : rdata0_q;
                rdata1_d = (own_q && !we_q) ? rf_rd_data : rdata1_q;
                state_d  = DONE;
            end
            DONE: begin
                prio_d  = !own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign rf_wr_e    = wr_e_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign rf_rd_addr = rd_addr_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_regfile_arbiter_2x.sv
// tb_regfile_arbiter_2x: directed bench with a behavioural 4x8 register file
module tb_regfile_arbiter_2x;
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [1:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic ack0, ack1, rf_wr_e, busy;
    logic [7:0] rdata0, rdata1, rf_wr_data, rf_rd_data;
    logic [1:0] rf_wr_addr, rf_rd_addr;
    logic [7:0] mem [4];
    int checks = 0, failures = 0;

    regfile_arbiter_2x #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rf_rd_data = mem[rf_rd_addr];
    always @(posedge clk) if (rf_wr_e) mem[rf_wr_addr] <= rf_wr_data;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++; if ({ack0, ack1, rf_wr_e, busy} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {ack0, ack1, rf_wr_e, busy}); end
        checks++; if ({rdata0, rdata1, rf_wr_data, rf_wr_addr, rf_rd_addr} !== 28'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {rdata0, rdata1, rf_wr_data, rf_wr_addr, rf_rd_addr}); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write;
        req0 = 1; we0 = 1; addr0 = 2; wdata0 = 8'hA5;
        tick;
        checks++; if ({rf_wr_e, rf_wr_addr, rf_wr_data, busy, ack0} !== {1'b1, 2'd2, 8'hA5, 1'b1, 1'b0}) begin failures++; $display("FAIL write_access got=%b/%0d/%h/%b/%b exp=1/2/a5/1/0", rf_wr_e, rf_wr_addr, rf_wr_data, busy, ack0); end
        tick;
        checks++; if ({ack0, ack1, rf_wr_e, busy} !== 4'b1001) begin failures++; $display("FAIL write_done got=%b exp=1001", {ack0, ack1, rf_wr_e, busy}); end
        checks++; if (mem[2] !== 8'hA5) begin failures++; $display("FAIL write_mem got=%h exp=a5", mem[2]); end
        req0 = 0;
        tick;
        checks++; if ({ack0, busy} !== 2'b00) begin failures++; $display("FAIL write_idle got=%b exp=00", {ack0, busy}); end
    endtask

    task automatic test_read;
        req1 = 1; we1 = 0; addr1 = 2;
        tick;
        checks++; if ({rf_rd_addr, rf_wr_e, busy} !== {2'd2, 1'b0, 1'b1}) begin failures++; $display("FAIL read_access got=%0d/%b/%b exp=2/0/1", rf_rd_addr, rf_wr_e, busy); end
        tick;
        checks++; if ({ack1, ack0, rdata1} !== {1'b1, 1'b0, 8'hA5}) begin failures++; $display("FAIL read_done got=%b/%b/%h exp=1/0/a5", ack1, ack0, rdata1); end
        checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL read_rdata0 got=%h exp=00", rdata0); end
        req1 = 0;
        tick;
        checks++; if ({ack1, rdata1} !== {1'b0, 8'hA5}) begin failures++; $display("FAIL read_hold got=%b/%h exp=0/a5", ack1, rdata1); end
    endtask

    task automatic test_contention;
        req0 = 1; we0 = 1; addr0 = 1; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 3; wdata1 = 8'h22;
        for (int c = 1; c <= 7; c++) begin
            tick;
            checks++; if ({ack0, ack1} !== {c == 2, c == 5}) begin failures++; $display("FAIL contention_ack cycle=%0d got=%b%b exp=%b%b", c, ack0, ack1, c == 2, c == 5); end
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
        end
        checks++; if ({mem[1], mem[3]} !== 16'h1122) begin failures++; $display("FAIL contention_mem got=%h exp=1122", {mem[1], mem[3]}); end
    endtask

    task automatic test_fairness;
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 3;
        for (int c = 1; c <= 12; c++) begin
            tick;
            checks++; if ({ack0, ack1} !== {c == 2 || c == 8, c == 5 || c == 11}) begin failures++; $display("FAIL fairness_ack cycle=%0d got=%b%b exp=%b%b", c, ack0, ack1, c == 2 || c == 8, c == 5 || c == 11); end
        end
        req0 = 0; req1 = 0;
        checks++; if ({rdata0, rdata1} !== 16'h1122) begin failures++; $display("FAIL fairness_rdata got=%h exp=1122", {rdata0, rdata1}); end
        repeat (2) tick;
    endtask

    task automatic test_reset_mid;
        req0 = 1; we0 = 0; addr0 = 2;
        repeat (2) tick;
        checks++; if ({ack0, rdata0} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL pre_reset_read got=%b/%h exp=1/a5", ack0, rdata0); end
        req0 = 0;
        repeat (2) tick;
        req0 = 1; we0 = 1; addr0 = 0; wdata0 = 8'hFF;
        tick;
        checks++; if ({rf_wr_e, rf_wr_addr, rf_wr_data} !== {1'b1, 2'd0, 8'hFF}) begin failures++; $display("FAIL mid_access got=%b/%0d/%h exp=1/0/ff", rf_wr_e, rf_wr_addr, rf_wr_data); end
        #1 rst = 1;
        #1;
        checks++; if ({ack0, ack1, rf_wr_e, busy} !== 4'b0) begin failures++; $display("FAIL mid_reset_ctl got=%b exp=0000", {ack0, ack1, rf_wr_e, busy}); end
        checks++; if ({rdata0, rdata1, rf_wr_data, rf_wr_addr, rf_rd_addr} !== 28'h0) begin failures++; $display("FAIL mid_reset_data got=%h exp=0", {rdata0, rdata1, rf_wr_data, rf_wr_addr, rf_rd_addr}); end
        req0 = 0;
        tick;
        rst = 0;
        tick;
        checks++; if ({ack0, busy, mem[0]} !== {2'b00, 8'h3C}) begin failures++; $display("FAIL mid_dropped got=%b%b/%h exp=00/3c", ack0, busy, mem[0]); end
        req0 = 1; we0 = 0; addr0 = 0;
        req1 = 1; we1 = 0; addr1 = 3;
        for (int c = 1; c <= 5; c++) begin
            tick;
            checks++; if ({ack0, ack1} !== {c == 2, c == 5}) begin failures++; $display("FAIL post_reset_ack cycle=%0d got=%b%b exp=%b%b", c, ack0, ack1, c == 2, c == 5); end
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
        end
        checks++; if ({rdata0, rdata1} !== 16'h3C22) begin failures++; $display("FAIL post_reset_rdata got=%h exp=3c22", {rdata0, rdata1}); end
    endtask

    initial begin
        mem[0] = 8'h3C; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_contention;
        tick;
        test_fairness;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter_2x.md
Name: regfile_arbiter_2x

Overview:
- Round-robin access controller that shares one 4x8 register file (one write port, one read port) between two requesters.
- Each requester issues single read or write transactions over a req/ack handshake.
- The arbiter sequences the register-file ports and returns read data to the winning requester.
- Sits between the two client blocks and the register file; it is the only driver of the register-file port signals.

Parameters:
- DATA_W, 8, register-file word width.
- ADDR_W, 2, register-file address width (2^ADDR_W entries).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 transaction request.
- we0  input  1  requester 0 op: 1 = write, 0 = read.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- ack0  output  1  requester 0 completion pulse (registered).
- rdata0  output  DATA_W  requester 0 read data, valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as requester 0, for requester 1.
- rf_wr_e  output  1  register-file write enable.
- rf_wr_addr  output  ADDR_W  register-file write address.
- rf_wr_data  output  DATA_W  register-file write data.
- rf_rd_addr  output  ADDR_W  register-file read address.
- rf_rd_data  input  DATA_W  register-file read data, combinational from rf_rd_addr.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Register file contract:
  - Writes mem[rf_wr_addr] at the rising edge when rf_wr_e=1.
  - rf_rd_data follows rf_rd_addr combinationally.
- All outputs are registered.
- Reset (asynchronous, any state):
  - state=IDLE, prio=0.
  - ack0=ack1=0, rdata0=rdata1=0.
  - rf_wr_e=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr=0, busy=0.
  - An in-flight transaction is dropped with no ack.
  - Register-file contents are not touched by the arbiter.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant requester prio.
  - On grant: latch owner, we, addr, wdata; go to ACCESS.
- ACCESS (exactly one cycle):
  - Write: rf_wr_e=1, rf_wr_addr=addr, rf_wr_data=wdata; write commits at the edge leaving ACCESS.
  - Read: rf_rd_addr=addr; rf_rd_data is captured into the owner's rdata at the edge leaving ACCESS.
  - Go to DONE.
- DONE (one cycle):
  - ack_owner=1; rf_wr_e=0.
  - rdata_owner holds the read result. For a write, rdata_owner is unchanged.
  - prio = ~owner.
  - Go to IDLE.
- Latency:
  - req sampled at edge E0 (IDLE) -> ACCESS during E0..E1 -> ack high during E1..E2.
  - Minimum transaction spacing is 3 cycles.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until it samples ack=1.
  - ack is a single-cycle pulse.
  - req still high in IDLE after DONE is a new transaction.
  - Inputs changing after grant are ignored (already latched).
- Fairness:
  - prio flips only on completion of a transaction.
  - A single active requester is served back-to-back regardless of prio.
  - Two continuously requesting clients alternate 0,1,0,1...
- Non-owner: ack stays 0 and rdata holds its last value.
- Read-after-write: a read granted after a completed write to the same address returns the new data.
- Width rules: addresses pass through unchanged; no address wrap logic; no arithmetic on data.
- At most one register-file port is active per cycle.

Test Plan:
- Reset: assert rst mid-run -> all outputs 0 immediately, busy=0; after release, first simultaneous request is granted to requester 0.
- Write: req0=1, we0=1, addr0=2, wdata0=8'hA5 at E0 -> rf_wr_e=1, rf_wr_addr=2, rf_wr_data=8'hA5 for one cycle; ack0=1 the following cycle; busy=1 for exactly 2 cycles.
- Read: after the write, req1=1, we1=0, addr1=2 -> rf_rd_addr=2 in ACCESS; ack1=1 with rdata1=8'hA5; rdata0 unchanged.
- Contention: req0 and req1 both high from E0 (write 0x11 to addr1 / write 0x22 to addr3) -> ack0 pulses in cycle 2, ack1 pulses in cycle 5.
- Fairness: both req held high for 12 cycles -> ack sequence 0,1,0,1 at 3-cycle spacing.
- Reset during ACCESS of a write to addr0=0 with data 8'hFF -> rf_wr_e drops asynchronously; no ack; a subsequent read of addr 0 returns its pre-reset value.
